// File: rtl/det_matrix_loader_pkg.sv
// Shared definitions for the determinant-engine matrix loader.
// The first word of every input stream is the size word: the matrix dimension N,
// followed by N*N elements in row-major order. The same N is returned to the
// engine as the first read after the matrix is released.
package det_pkg;

  localparam int DET_DATA_W = 20;
  localparam int DET_MAX_N  = 8;
  localparam int DET_IDX_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } det_state_e;

endpackage

// File: rtl/det_matrix_loader_mat_store.sv
// Element register file: one synchronous write port, one asynchronous read port.
// Contents are data only and carry no reset.
module mat_store
  import det_pkg::*;
#(
  parameter int DATA_W = DET_DATA_W,
  parameter int DEPTH  = DET_MAX_N * DET_MAX_N,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write one element per accepted stream word
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/det_matrix_loader.sv
// Matrix loader in front of the determinant engine: takes a size word plus N*N
// elements from a valid/ready stream, then holds the engine out of reset and
// answers its (i, j) reads combinationally until the engine signals finish.
module det_matrix_loader
  import det_pkg::*;
#(
  parameter int DATA_W = DET_DATA_W,
  parameter int MAX_N  = DET_MAX_N,
  parameter int IDX_W  = DET_IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              det_rst,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  input  logic              read,
  input  logic              finish,
  output logic [DATA_W-1:0] read_data,
  output logic              loaded,
  output logic              err
);

  localparam int N_W    = $clog2(MAX_N + 1);
  localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int DEPTH  = MAX_N * MAX_N;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  det_state_e         r_state;
  logic [N_W-1:0]     r_n;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   r_col;
  logic               r_size_phase;
  logic               r_err;

  logic               w_serving;
  logic               w_hdr_ok;
  logic               w_last_col;
  logic               w_last_row;
  logic               w_we;
  logic               w_in_range;
  logic [ADDR_W-1:0]  w_waddr;
  logic [ADDR_W-1:0]  w_raddr;
  logic [DATA_W-1:0]  w_rdata;

  // Outputs are gated by reset_n so the engine is held the instant reset is seen
  assign w_serving = reset_n && (r_state == ST_SERVE);
  assign in_ready  = reset_n && (r_state != ST_SERVE);
  assign det_rst   = !w_serving;
  assign loaded    = w_serving;
  assign err       = reset_n && r_err;

  assign w_hdr_ok   = (in_data != '0) && (in_data <= DATA_W'(MAX_N));
  assign w_last_col = (N_W'(r_col) == (r_n - N_W'(1)));
  assign w_last_row = (N_W'(r_row) == (r_n - N_W'(1)));
  assign w_we       = reset_n && (r_state == ST_LOAD) && in_valid;
  assign w_waddr    = ADDR_W'(r_row) * ADDR_W'(MAX_N) + ADDR_W'(r_col);

  // Full-width compare so large indices never alias into the array
  assign w_in_range = (i < IDX_W'(r_n)) && (j < IDX_W'(r_n));
  assign w_raddr    = ADDR_W'(i[CNT_W-1:0]) * ADDR_W'(MAX_N) + ADDR_W'(j[CNT_W-1:0]);

  mat_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (in_data),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // Read mux: size word first, then range-checked elements, zero outside SERVE
  always_comb begin
    read_data = '0;
    if (w_serving) begin
      if (r_size_phase) begin
        read_data = DATA_W'(r_n);
      end else if (w_in_range) begin
        read_data = w_rdata;
      end
    end
  end

  // Loader FSM: header check, row-major element counting, serve/finish handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_size_phase <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_hdr_ok) begin
              r_n     <= N_W'(in_data);
              r_row   <= '0;
              r_col   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_state      <= ST_SERVE;
                r_size_phase <= 1'b1;
              end else begin
                r_row <= r_row + CNT_W'(1);
              end
            end else begin
              r_col <= r_col + CNT_W'(1);
            end
          end
        end
        ST_SERVE: begin
          if (read) begin
            r_size_phase <= 1'b0;
          end
          if (finish) begin
            r_state      <= ST_IDLE;
            r_size_phase <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/det_matrix_loader.md
# det_matrix_loader

Upstream stage of the determinant engine. Accepts a matrix as a valid/ready word stream and stores it in an internal register file. It then releases the determinant engine and serves that engine's (i, j) element reads with zero-latency combinational data. When the engine raises `finish`, the loader returns to idle and is ready for the next matrix.

## Interface
Parameters:
- DATA_W, 20, width of stream words and element data
- MAX_N, 8, largest supported matrix dimension
- IDX_W, 20, width of the engine's i/j indices

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  stream word present
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  DATA_W  stream word: header N first, then N*N elements in row-major order
- det_rst  out  1  active-high hold/reset to the engine; high whenever the loader is not serving
- i  in  IDX_W  engine row index
- j  in  IDX_W  engine column index
- read  in  1  engine read strobe
- finish  in  1  engine done
- read_data  out  DATA_W  size word or element, combinational
- loaded  out  1  high while serving
- err  out  1  one-cycle pulse when a header is rejected

The decided clock/reset arrangement is one clock with synchronous, active-low reset: `clk`, `reset_n`.

## Operation
States: IDLE, LOAD, SERVE.

- IDLE
  - in_ready=1.
  - A header is accepted when in_valid && in_ready at the clock edge.
  - Valid header (1 ≤ N ≤ MAX_N): latch N, clear the element counter, go to LOAD.
  - Invalid header (N=0 or N>MAX_N): pulse err for 1 cycle, stay in IDLE.
- LOAD
  - in_ready=1.
  - Each accepted word goes to mem[r*MAX_N + c], with r/c advancing row-major (c wraps to 0 at N-1 and r increments).
  - The last element (r=c=N-1) moves the loader to SERVE.
  - Gaps in in_valid stall the load without loss.
- SERVE
  - in_ready=0, det_rst=0, loaded=1.
  - size_phase is set on entry.
    - While size_phase=1, read_data=N zero-extended.
    - size_phase clears after the first cycle with read=1.
  - After size_phase clears, read_data = mem[i*MAX_N + j] when i<N and j<N; otherwise 0.
  - finish=1 sampled at a clock edge moves the loader to IDLE.
- Outside SERVE: det_rst=1, read_data=0.
- Storage is a plain register file. It is not cleared between matrices; stale entries beyond N are unreachable because of the range check.

## Timing
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, counters=0, N=0, size_phase=0.
  - While reset_n is low: in_ready=0, det_rst=1, loaded=0, err=0, read_data=0.
- Reset mid-LOAD or mid-SERVE aborts to IDLE. The partial matrix is discarded and det_rst reasserts in the same cycle reset is sampled.
- Header-to-SERVE latency: N*N+1 accepted words. det_rst falls in the cycle after the last element is accepted.
- read_data has 0-cycle latency from i, j, and size_phase.
- finish→IDLE: 1 cycle. in_ready rises and det_rst rises in the cycle after finish is sampled. A header can be accepted in that same cycle.
- in_valid while in SERVE is ignored (in_ready=0). Upstream holds its word.
- err is coincident with the cycle after the bad header is accepted.

## Structure
- Package det_pkg holds:
  - DATA_W, IDX_W, MAX_N defaults
  - state encodings ST_IDLE/ST_LOAD/ST_SERVE
  - the size-word convention (first word = dimension)
- Sub-module mat_store holds the MAX_N*MAX_N x DATA_W register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port. The FSM, counters and range check stay in det_matrix_loader.

## Test plan
- 2x2 load: stream 2,3,5,7,11 with no gaps. Expect:
  - det_rst falls after the 5th accept.
  - First read returns 2.
  - Then (0,0)=3, (0,1)=5, (1,0)=7, (1,1)=11.
- Backpressure: 3x3 load (header 3, elements 1..9) with in_valid toggled every other cycle. Expect exactly 10 accepts, then element (2,1) reads 8.
- Bad headers: send 0, then MAX_N+1. Expect an err pulse for each, state stays IDLE and det_rst stays high. Then a valid 1x1 header 1 and element 42: the size read returns 1 and (0,0) reads 42.
- Out of range: in SERVE with N=2, read (2,0) and (0,5). Both return 0.
- Back-to-back matrices: assert finish in SERVE. Expect IDLE one cycle later. Load 2x2 (9,8,7,6): (1,0) reads 7 and no stale data is seen.
- Reset mid-LOAD: deassert reset_n after 3 of 4 elements. Expect in_ready=0 and det_rst=1 during reset, then IDLE. A full reload then succeeds.
